// File: rtl/branch_predictor.sv
// 2-bit saturating-counter direction predictor for the fetch stage, trained at execute.
// Optional gshare indexing (global history XOR PC) is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned GHR_BITS = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pred_valid,
    input  logic [31:0]         pred_pc,
    output logic                pred_out_valid,
    output logic                pred_taken,
    output logic [IDX_BITS-1:0] pred_idx,
    input  logic                res_valid,
    input  logic [IDX_BITS-1:0] res_idx,
    input  logic                res_taken,
    input  logic                res_pred,
    output logic                mispredict
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    logic [1:0]          r_table [ENTRIES];
    logic [IDX_BITS-1:0] w_lookup_idx;
    logic [1:0]          w_cur_ctr;
    logic [1:0]          w_next_ctr;
    logic                w_unused_pc;

    // Word-aligned PC: low two bits and bits above the index carry no table information.
    assign w_unused_pc = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] r_ghr;

    // History is committed at resolve only, so a squashed path never pollutes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (res_valid) begin
            r_ghr <= GHR_BITS'({r_ghr, res_taken});
        end
    end

    assign w_lookup_idx = pred_pc[IDX_BITS+1:2] ^ IDX_BITS'(r_ghr);
`else
    localparam int unsigned unused_ghr_bits = GHR_BITS;

    assign w_lookup_idx = pred_pc[IDX_BITS+1:2];
`endif

    // Saturating increment/decrement of the counter being trained.
    always_comb begin
        w_cur_ctr  = r_table[res_idx];
        w_next_ctr = w_cur_ctr;
        if (res_taken) begin
            if (w_cur_ctr != 2'b11) begin
                w_next_ctr = w_cur_ctr + 2'd1;
            end
        end else begin
            if (w_cur_ctr != 2'b00) begin
                w_next_ctr = w_cur_ctr - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_table[i] <= 2'b01;
            end
        end else if (res_valid) begin
            r_table[res_idx] <= w_next_ctr;
        end
    end

    // Lookup reads the pre-update table, giving read-before-write on a same-index collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_out_valid <= 1'b0;
            pred_taken     <= 1'b0;
            pred_idx       <= '0;
            mispredict     <= 1'b0;
        end else begin
            pred_out_valid <= pred_valid;
            if (pred_valid) begin
                pred_taken <= r_table[w_lookup_idx][1];
                pred_idx   <= w_lookup_idx;
            end
            mispredict <= res_valid & (res_taken ^ res_pred);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor: training, saturation, collision,
// back-to-back updates, mispredict pulse, gshare indexing and asynchronous reset.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_out_valid;
    logic        pred_taken;
    logic [5:0]  pred_idx;
    logic        res_valid;
    logic [5:0]  res_idx;
    logic        res_taken;
    logic        res_pred;
    logic        mispredict;

    int n_tests;
    int n_failed;

    branch_predictor #(.IDX_BITS(6), .GHR_BITS(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_out_valid (pred_out_valid),
        .pred_taken     (pred_taken),
        .pred_idx       (pred_idx),
        .res_valid      (res_valid),
        .res_idx        (res_idx),
        .res_taken      (res_taken),
        .res_pred       (res_pred),
        .mispredict     (mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        rv;
        logic [5:0]  ri;
        logic        rt;
        logic        rp;
        logic        e_pov;
        logic        e_pt;
        logic [5:0]  e_pi;
        logic        e_mp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic pov, input logic pt,
                              input logic [5:0] pi, input logic mp);
        check({tag, ".pred_out_valid"}, 32'(pred_out_valid), 32'(pov));
        check({tag, ".pred_taken"},     32'(pred_taken),     32'(pt));
        check({tag, ".pred_idx"},       32'(pred_idx),       32'(pi));
        check({tag, ".mispredict"},     32'(mispredict),     32'(mp));
    endtask

    function automatic void add(input logic pv, input logic [31:0] pc, input logic rv,
                                input logic [5:0] ri, input logic rt, input logic rp,
                                input logic e_pov, input logic e_pt, input logic [5:0] e_pi,
                                input logic e_mp);
        vec_t v;
        v.pv = pv; v.pc = pc; v.rv = rv; v.ri = ri; v.rt = rt; v.rp = rp;
        v.e_pov = e_pov; v.e_pt = e_pt; v.e_pi = e_pi; v.e_mp = e_mp;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs (called just after a rising edge), then sample 1ns after the next.
    task automatic step(input logic pv, input logic [31:0] pc, input logic rv,
                        input logic [5:0] ri, input logic rt, input logic rp);
        pred_valid = pv; pred_pc = pc;
        res_valid = rv; res_idx = ri; res_taken = rt; res_pred = rp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pred_valid = 1'b0; pred_pc = '0;
        res_valid = 1'b0; res_idx = '0; res_taken = 1'b0; res_pred = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b0, 6'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    logic [31:0] lk_pc;

    initial begin
        n_tests  = 0;
        n_failed = 0;
        rst_n    = 1'b0;
        idle_inputs();

`ifndef BP_GSHARE_EN
        // pv  pc           rv  ri  rt  rp   pov pt  pi  mp
        add(1, 32'h40,      0,  0,  0,  0,   1,  0,  16, 0); // untrained lookup: weak-NT
        add(0, 32'h0,       0,  0,  0,  0,   0,  0,  16, 0); // outputs hold
        add(0, 32'h0,       1,  3,  1,  0,   0,  0,  16, 1); // ctr3 01->10, mispredict
        add(1, 32'hC,       0,  0,  0,  0,   1,  1,  3,  0);
        add(0, 32'h0,       1,  3,  0,  1,   0,  1,  3,  1); // ctr3 10->01
        add(1, 32'hC,       0,  0,  0,  0,   1,  0,  3,  0);
        add(1, 32'h1C,      1,  7,  1,  1,   1,  0,  7,  0); // collision: pre-update 01
        add(0, 32'h0,       1,  7,  1,  1,   0,  0,  7,  0); // ctr7 -> 11
        add(1, 32'h1C,      1,  7,  1,  1,   1,  1,  7,  0); // saturated taken
        add(0, 32'h0,       1,  7,  1,  1,   0,  1,  7,  0);
        add(0, 32'h0,       1,  7,  1,  1,   0,  1,  7,  0); // 5th taken, still 11
        add(0, 32'h0,       1,  7,  0,  1,   0,  1,  7,  1); // 11->10
        add(1, 32'h1C,      0,  0,  0,  0,   1,  1,  7,  0); // weak-T
        add(0, 32'h0,       1,  7,  0,  0,   0,  1,  7,  0); // 10->01
        add(0, 32'h0,       1,  7,  0,  0,   0,  1,  7,  0); // 01->00
        add(0, 32'h0,       1,  7,  0,  0,   0,  1,  7,  0); // stays 00
        add(1, 32'h1C,      0,  0,  0,  0,   1,  0,  7,  0); // no wrap to 11
        add(0, 32'h0,       1,  7,  1,  0,   0,  0,  7,  1); // 00->01
        add(1, 32'h1C,      0,  0,  0,  0,   1,  0,  7,  0); // 01, not 10
        add(1, 32'h14,      1,  5,  1,  0,   1,  0,  5,  1); // collision idx5
        add(1, 32'h14,      0,  0,  0,  0,   1,  1,  5,  0); // update not lost
        add(0, 32'h0,       1,  5,  0,  1,   0,  1,  5,  1); // back-to-back 10->01
        add(0, 32'h0,       1,  5,  0,  1,   0,  1,  5,  1); // 01->00
        add(0, 32'h0,       1,  5,  1,  0,   0,  1,  5,  1); // 00->01
        add(1, 32'h14,      0,  0,  0,  0,   1,  0,  5,  0);
        add(1, 32'h17,      0,  0,  0,  0,   1,  0,  5,  0); // PC[1:0] ignored
        add(1, 32'h100C,    0,  0,  0,  0,   1,  0,  3,  0); // upper PC bits ignored
        add(0, 32'h0,       0,  0,  0,  0,   0,  0,  3,  0); // single-cycle valid

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].pv, vecs[i].pc, vecs[i].rv, vecs[i].ri, vecs[i].rt, vecs[i].rp);
            check_outs($sformatf("vec%0d", i), vecs[i].e_pov, vecs[i].e_pt,
                       vecs[i].e_pi, vecs[i].e_mp);
        end
        lk_pc = 32'hC;
`else
        lk_pc = 32'h0;
`endif

        // Train idx3 to strong-T; with gshare the two taken resolves also make GHR 6'b000011.
        do_reset();
        step(0, 32'h0, 1, 6'd3, 1, 1);
        check_outs("train_a", 1'b0, 1'b0, 6'd0, 1'b0);
        step(0, 32'h0, 1, 6'd3, 1, 1);
        check_outs("train_b", 1'b0, 1'b0, 6'd0, 1'b0);
        // Lookup maps to idx3 in both builds, with a mispredicting resolve in flight.
        step(1, lk_pc, 1, 6'd3, 1, 0);
        check_outs("pre_rst", 1'b1, 1'b1, 6'd3, 1'b1);

        // Asynchronous reset between edges clears outputs without a clock.
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 6'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // GHR cleared: PC 0 maps to idx 0; training at idx3 discarded.
        step(1, 32'h0, 0, 6'd0, 0, 0);
        check_outs("post_rst_pc0", 1'b1, 1'b0, 6'd0, 1'b0);
        step(1, 32'hC, 0, 6'd0, 0, 0);
        check_outs("post_rst_pc c", 1'b1, 1'b0, 6'd3, 1'b0);
        step(0, 32'h0, 0, 6'd0, 0, 0);
        check_outs("post_rst_idle", 1'b0, 1'b0, 6'd3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
